// File: rtl/mem_pkg.sv
// Shared definitions for the OTTER data-memory port: access sizes, RV32I load/store
// width encodings, exception codes and the load/store unit state encoding.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] EXC_LOAD_ACCESS      = 4'd5;
  localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] EXC_STORE_ACCESS     = 4'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // Store variants of each exception sit two codes above the load variants.
  function automatic logic [3:0] exc_for(input logic [3:0] load_code, input logic is_store);
    return load_code + (is_store ? 4'd2 : 4'd0);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/half lane of a memory read word and sign- or
// zero-extends it according to the RV32I load funct3.
module load_extend
  import mem_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic [BUS_WIDTH-1:0] mem_out,
  input  logic [1:0]           offset,
  input  logic [2:0]           funct3,
  output logic [BUS_WIDTH-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = mem_out[{offset, 3'b000} +: 8];
  assign half_lane = mem_out[{offset[1], 4'b0000} +: 16];

  always_comb begin
    result = mem_out;
    case (funct3[1:0])
      BYTE:    result = funct3[2] ? {{(BUS_WIDTH-8){1'b0}}, byte_lane}
                                  : {{(BUS_WIDTH-8){byte_lane[7]}}, byte_lane};
      HALF:    result = funct3[2] ? {{(BUS_WIDTH-16){1'b0}}, half_lane}
                                  : {{(BUS_WIDTH-16){half_lane[15]}}, half_lane};
      default: result = mem_out;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side initiator for the OTTER data memory: one load/store per handshake,
// with alignment/range checking, store lane placement and load extension.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 15,
  parameter int BUS_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [BUS_WIDTH-1:0] addr,
  input  logic [BUS_WIDTH-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] rdata,
  output logic                 fault,
  output logic [3:0]           exc_code,
  output logic                 mem_rd,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_data,
  output logic [1:0]           mem_size,
  input  logic [BUS_WIDTH-1:0] mem_out,
  input  logic                 mem_error
);

  localparam logic [BUS_WIDTH-1:0] ADDR_MAX = BUS_WIDTH'((64'd1 << ADDR_WIDTH) - 64'd1);

  lsu_state_e           state, state_d;
  logic                 is_store_q;
  logic [2:0]           funct3_q;
  logic [BUS_WIDTH-1:0] addr_q;
  logic [BUS_WIDTH-1:0] wdata_q;
  logic [BUS_WIDTH-1:0] load_result;
  logic                 fault_det;
  logic [3:0]           fault_code;

  load_extend #(.BUS_WIDTH(BUS_WIDTH)) u_load_extend (
    .mem_out (mem_out),
    .offset  (addr_q[1:0]),
    .funct3  (funct3_q),
    .result  (load_result)
  );

  assign busy     = (state != IDLE);
  assign done     = (state == RESP);
  assign mem_addr = addr_q;
  assign mem_size = funct3_q[1:0];
  assign mem_data = wdata_q << {addr_q[1:0], 3'b000};

  // Unsupported width beats misalignment, which beats range/memory errors.
  always_comb begin
    fault_det  = 1'b0;
    fault_code = 4'd0;
    if (funct3_q[1:0] == 2'b11) begin
      fault_det  = 1'b1;
      fault_code = exc_for(EXC_LOAD_ACCESS, is_store_q);
    end else if ((funct3_q[1:0] == HALF && addr_q[0]) ||
                 (funct3_q[1:0] == WORD && addr_q[1:0] != 2'b00)) begin
      fault_det  = 1'b1;
      fault_code = exc_for(EXC_LOAD_MISALIGNED, is_store_q);
    end else if (addr_q > ADDR_MAX || mem_error) begin
      fault_det  = 1'b1;
      fault_code = exc_for(EXC_LOAD_ACCESS, is_store_q);
    end
  end

  always_comb begin
    state_d = state;
    mem_rd  = 1'b0;
    mem_we  = 1'b0;
    case (state)
      IDLE:  if (req) state_d = ISSUE;
      ISSUE: begin
        if (fault_det) begin
          state_d = RESP;
        end else if (is_store_q) begin
          mem_we  = 1'b1;
          state_d = RESP;
        end else begin
          mem_rd  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata      <= '0;
      fault      <= 1'b0;
      exc_code   <= 4'd0;
    end else begin
      state <= state_d;
      if (state == IDLE && req) begin
        is_store_q <= is_store;
        funct3_q   <= funct3;
        addr_q     <= addr;
        wdata_q    <= wdata;
      end
      if (state == ISSUE) begin
        fault    <= fault_det;
        exc_code <= fault_det ? fault_code : 4'd0;
        if (fault_det || is_store_q) rdata <= '0;
      end
      if (state == WAIT) rdata <= load_result;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit paired with a small behavioural data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [3:0]  exc_code;
  logic        mem_rd;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [1:0]  mem_size;
  logic [31:0] mem_out;
  logic        mem_error;
  logic        mem_err_force;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(15), .BUS_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .is_store  (is_store),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .fault     (fault),
    .exc_code  (exc_code),
    .mem_rd    (mem_rd),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_size  (mem_size),
    .mem_out   (mem_out),
    .mem_error (mem_error)
  );

  assign mem_error = mem_err_force;

  // Behavioural memory: byte-enabled writes, registered reads.
  always @(posedge clk) begin
    if (mem_we && mem_addr < 32'h8000) begin
      for (int b = 0; b < 4; b++) begin
        if ((mem_size == 2'b10) ||
            (mem_size == 2'b01 && (b >> 1) == int'(mem_addr[1])) ||
            (mem_size == 2'b00 && b == int'(mem_addr[1:0])))
          mem[mem_addr[14:2]][8*b +: 8] <= mem_data[8*b +: 8];
      end
    end
    if (mem_rd) mem_out <= mem[mem_addr[14:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request, pulses a stray req while busy, and checks the response.
  task automatic op(input string tag, input logic st, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input int exp_cyc, input logic exp_fault, input logic [3:0] exp_exc,
                    input logic [31:0] exp_rdata, input logic [31:0] exp_mdata,
                    input logic [1:0] exp_size);
    int          we_cnt = 0;
    int          rd_cnt = 0;
    int          cyc    = 0;
    int          extra  = 0;
    logic [31:0] seen_data = '0;
    logic [1:0]  seen_size = '0;
    logic [31:0] r = '0;
    logic        f = 1'b0;
    logic [3:0]  e = '0;
    @(negedge clk);
    req = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (mem_we) begin we_cnt++; seen_data = mem_data; seen_size = mem_size; end
      if (mem_rd) rd_cnt++;
      if (done) begin cyc = c; r = rdata; f = fault; e = exc_code; break; end
      req = (c == 1);
      @(negedge clk);
      req = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_fault"}, 32'(f), 32'(exp_fault));
    chk({tag, "_exc"}, 32'(e), 32'(exp_exc));
    chk({tag, "_rdata"}, r, exp_rdata);
    chk({tag, "_we_count"}, 32'(we_cnt), 32'(st && !exp_fault));
    chk({tag, "_rd_count"}, 32'(rd_cnt), 32'(!st && !exp_fault));
    chk({tag, "_extra_done"}, 32'(extra), 32'd0);
    if (st && !exp_fault) begin
      chk({tag, "_mem_data"}, seen_data, exp_mdata);
      chk({tag, "_mem_size"}, 32'(seen_size), 32'(exp_size));
    end
  endtask

  initial begin
    int stray;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    mem_out = '0;
    mem_err_force = 1'b0;
    rst = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_exc", 32'(exc_code), 32'd0);
    rst = 1'b0;

    //  tag        st    f3      addr        wdata         cyc flt exc   rdata         mdata         size
    op("sw_100",   1'b1, 3'b010, 32'h100,  32'hDEADBEEF, 2, 0, 4'd0, 32'h0,        32'hDEADBEEF, 2'b10);
    op("lw_100",   1'b0, 3'b010, 32'h100,  32'h0,        3, 0, 4'd0, 32'hDEADBEEF, 32'h0,        2'b00);
    op("sb_103",   1'b1, 3'b000, 32'h103,  32'h000000A5, 2, 0, 4'd0, 32'h0,        32'hA5000000, 2'b00);
    op("lb_103",   1'b0, 3'b000, 32'h103,  32'h0,        3, 0, 4'd0, 32'hFFFFFFA5, 32'h0,        2'b00);
    op("lbu_103",  1'b0, 3'b100, 32'h103,  32'h0,        3, 0, 4'd0, 32'h000000A5, 32'h0,        2'b00);
    op("lw_100b",  1'b0, 3'b010, 32'h100,  32'h0,        3, 0, 4'd0, 32'hA5ADBEEF, 32'h0,        2'b00);
    op("sh_102",   1'b1, 3'b001, 32'h102,  32'h00008001, 2, 0, 4'd0, 32'h0,        32'h80010000, 2'b01);
    op("lh_102",   1'b0, 3'b001, 32'h102,  32'h0,        3, 0, 4'd0, 32'hFFFF8001, 32'h0,        2'b00);
    op("lhu_102",  1'b0, 3'b101, 32'h102,  32'h0,        3, 0, 4'd0, 32'h00008001, 32'h0,        2'b00);
    op("lw_mis",   1'b0, 3'b010, 32'h102,  32'h0,        2, 1, 4'd4, 32'h0,        32'h0,        2'b00);
    op("sh_mis",   1'b1, 3'b001, 32'h101,  32'h1234,     2, 1, 4'd6, 32'h0,        32'h0,        2'b00);
    op("lw_range", 1'b0, 3'b010, 32'h8000, 32'h0,        2, 1, 4'd5, 32'h0,        32'h0,        2'b00);
    op("sw_range", 1'b1, 3'b010, 32'h8000, 32'h5555AAAA, 2, 1, 4'd7, 32'h0,        32'h0,        2'b00);
    op("f3_11",    1'b0, 3'b011, 32'h101,  32'h0,        2, 1, 4'd5, 32'h0,        32'h0,        2'b00);
    mem_err_force = 1'b1;
    op("mem_err",  1'b0, 3'b010, 32'h200,  32'h0,        2, 1, 4'd5, 32'h0,        32'h0,        2'b00);
    mem_err_force = 1'b0;

    // Reset while a load sits in WAIT: no done, idle immediately afterwards.
    stray = 0;
    @(negedge clk);
    req = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100;
    @(negedge clk);
    req = 1'b0;
    if (done) stray++;
    @(negedge clk);
    if (done) stray++;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_busy", 32'(busy), 32'd0);
    chk("rst_wait_done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) stray++;
    end
    chk("rst_wait_no_done", 32'(stray), 32'd0);

    op("lw_post",  1'b0, 3'b010, 32'h100,  32'h0,        3, 0, 4'd0, 32'h8001BEEF, 32'h0,        2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
